id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter N, default 32, operand data width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports Valid_i, Stall_i, Flush_i  input  1 each  incoming-instruction valid, external hold, pipeline squash.
REQ-005 SHALL have ports Reg_Write_i, Mem_Read_i, Mem_Write_i, Mem_To_Reg_i, ALU_Src_i  input  1 each  decoded control.
REQ-006 SHALL have port ALU_Op_i  input  4  ALU operation code.
REQ-007 SHALL have ports Read_Register_1_i, Read_Register_2_i, Write_Register_i  input  5 each  source and destination indices.
REQ-008 SHALL have ports Read_Data_1_i, Read_Data_2_i, Immediate_i  input  N each  register-file read data, sign-extended immediate.
REQ-009 SHALL have ports WB_Reg_Write_i  input  1, WB_Write_Register_i  input  5, WB_Write_Data_i  input  N  write-back bus driving the register file this cycle.
REQ-010 SHALL have registered outputs Valid_o, all control bits (suffix _o), Read_Register_1_o, Read_Register_2_o, Write_Register_o, Operand_1_o, Operand_2_o, Immediate_o, matching input widths.
REQ-011 SHALL have Hazard_Stall_o  output  1  combinational load-use stall request to fetch/decode.
REQ-012 SHALL have Bubble_Count_o  output  16  saturating count of inserted bubbles.

Function
REQ-013 SHALL evaluate each edge with priority: Flush_i > Stall_i > Hazard_Stall_o > capture.
REQ-014 Flush_i=1 SHALL clear Valid_o and all control outputs to 0 next edge; data outputs don't-care.
REQ-015 Stall_i=1 (no flush) SHALL hold all outputs, except operand refresh per REQ-019.
REQ-016 Hazard_Stall_o SHALL be 1 iff Valid_o & Mem_Read_o & Write_Register_o!=0 & Valid_i & (Write_Register_o==Read_Register_1_i | Write_Register_o==Read_Register_2_i).
REQ-017 Hazard (no flush/stall) SHALL insert bubble: Valid_o and control outputs 0 next edge, Bubble_Count_o +1 saturating at 16'hFFFF; upstream holds instruction, so it is captured the following edge.
REQ-018 Capture SHALL load all _i fields into _o with 1-cycle latency; Valid_i=0 loads Valid_o=0 and zero control.
REQ-019 Bypass: when WB_Reg_Write_i=1, WB_Write_Register_i!=0 and equals source index, Operand_x_o SHALL take WB_Write_Data_i instead of Read_Data_x_i; during Stall_i hold, a matching write-back SHALL update the held Operand_x_o against Read_Register_x_o.
REQ-020 Register 0 SHALL never be bypassed; both operands bypass independently, same cycle.
REQ-021 Hazard_Stall_o SHALL be 0 when Flush_i=1.

Reset
REQ-022 reset=0 SHALL asynchronously clear every registered output, including Bubble_Count_o, to 0.
REQ-023 Deassertion mid-stream SHALL resume at next rising edge with no pending bubble.

Structure
REQ-024 Shared package SHALL hold REG_IDX_W=5, ALU_OP_W=4, ZERO_REG=0, BUBBLE_CNT_W=16.
REQ-025 Bypass selection SHALL be sub-module forward_mux, instantiated once per operand.

Verification
REQ-026 Capture: Valid_i=1, Read_Register_1_i=2, Read_Data_1_i=7, no WB -> Operand_1_o=7, Valid_o=1 after one edge.
REQ-027 Bypass: Read_Register_2_i=4, Read_Data_2_i=20, WB writes reg 4 with 99 same cycle -> Operand_2_o=99; WB to reg 0 with 55 -> no bypass.
REQ-028 Load-use: lw writing reg 25 in stage, next reads reg 25 -> Hazard_Stall_o=1, bubble, Bubble_Count_o=1, instruction captured next edge.
REQ-029 Stall refresh: hold with Read_Register_1_o=31, WB writes 78 to reg 31 -> Operand_1_o=78, other outputs unchanged.
REQ-030 Priority/reset: Flush_i and Stall_i together -> Valid_o=0; reset low mid-stream -> all outputs 0 immediately, no clock.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control bundle and helpers for the ID/EX pipeline register.
// Imported by id_ex_stage and its operand forwarding mux.
package id_ex_stage_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int ALU_OP_W     = 4;
  localparam int BUBBLE_CNT_W = 16;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(
    input logic [BUBBLE_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Write-back bypass for one operand: picks the write-back data when it
// targets the same non-zero register as the operand source.
module forward_mux
  import id_ex_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [REG_IDX_W-1:0] src_idx_i,
  input  logic [N-1:0]         src_data_i,
  input  logic                 wb_we_i,
  input  logic [REG_IDX_W-1:0] wb_idx_i,
  input  logic [N-1:0]         wb_data_i,
  output logic [N-1:0]         data_o
);

  logic hit;

  assign hit = wb_we_i
             & (wb_idx_i != ZERO_REG)
             & (wb_idx_i == src_idx_i);

  assign data_o = hit ? wb_data_i : src_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall, load-use bubble insertion,
// write-back bypass and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Valid_i,
  input  logic                    Stall_i,
  input  logic                    Flush_i,
  input  logic                    Reg_Write_i,
  input  logic                    Mem_Read_i,
  input  logic                    Mem_Write_i,
  input  logic                    Mem_To_Reg_i,
  input  logic                    ALU_Src_i,
  input  logic [ALU_OP_W-1:0]     ALU_Op_i,
  input  logic [REG_IDX_W-1:0]    Read_Register_1_i,
  input  logic [REG_IDX_W-1:0]    Read_Register_2_i,
  input  logic [REG_IDX_W-1:0]    Write_Register_i,
  input  logic [N-1:0]            Read_Data_1_i,
  input  logic [N-1:0]            Read_Data_2_i,
  input  logic [N-1:0]            Immediate_i,
  input  logic                    WB_Reg_Write_i,
  input  logic [REG_IDX_W-1:0]    WB_Write_Register_i,
  input  logic [N-1:0]            WB_Write_Data_i,
  output logic                    Valid_o,
  output logic                    Reg_Write_o,
  output logic                    Mem_Read_o,
  output logic                    Mem_Write_o,
  output logic                    Mem_To_Reg_o,
  output logic                    ALU_Src_o,
  output logic [ALU_OP_W-1:0]     ALU_Op_o,
  output logic [REG_IDX_W-1:0]    Read_Register_1_o,
  output logic [REG_IDX_W-1:0]    Read_Register_2_o,
  output logic [REG_IDX_W-1:0]    Write_Register_o,
  output logic [N-1:0]            Operand_1_o,
  output logic [N-1:0]            Operand_2_o,
  output logic [N-1:0]            Immediate_o,
  output logic                    Hazard_Stall_o,
  output logic [BUBBLE_CNT_W-1:0] Bubble_Count_o
);

  logic                    valid_q, valid_d;
  ctrl_t                   ctrl_q, ctrl_d, ctrl_in;
  logic [REG_IDX_W-1:0]    rr1_q, rr1_d;
  logic [REG_IDX_W-1:0]    rr2_q, rr2_d;
  logic [REG_IDX_W-1:0]    wr_q, wr_d;
  logic [N-1:0]            op1_q, op1_d;
  logic [N-1:0]            op2_q, op2_d;
  logic [N-1:0]            imm_q, imm_d;
  logic [BUBBLE_CNT_W-1:0] bub_q, bub_d;

  logic [REG_IDX_W-1:0]    src1_idx, src2_idx;
  logic [N-1:0]            src1_data, src2_data;
  logic [N-1:0]            fwd1, fwd2;
  logic                    hazard;
  logic                    sel_flush, sel_stall;
  logic                    sel_bubble, sel_cap;

  assign ctrl_in = '{
    reg_write:  Reg_Write_i,
    mem_read:   Mem_Read_i,
    mem_write:  Mem_Write_i,
    mem_to_reg: Mem_To_Reg_i,
    alu_src:    ALU_Src_i,
    alu_op:     ALU_Op_i
  };

  // Load in EX whose destination is read by the incoming instruction.
  assign hazard = ~Flush_i
                & valid_q
                & ctrl_q.mem_read
                & (wr_q != ZERO_REG)
                & Valid_i
                & ((wr_q == Read_Register_1_i)
                 | (wr_q == Read_Register_2_i));

  assign sel_flush  = Flush_i;
  assign sel_stall  = ~Flush_i & Stall_i;
  assign sel_bubble = ~Flush_i & ~Stall_i & hazard;
  assign sel_cap    = ~Flush_i & ~Stall_i & ~hazard;

  // While held, forward against the held operands instead of new ones.
  assign src1_idx  = Stall_i ? rr1_q : Read_Register_1_i;
  assign src2_idx  = Stall_i ? rr2_q : Read_Register_2_i;
  assign src1_data = Stall_i ? op1_q : Read_Data_1_i;
  assign src2_data = Stall_i ? op2_q : Read_Data_2_i;

  forward_mux #(.N(N)) u_fwd1 (
    .src_idx_i  (src1_idx),
    .src_data_i (src1_data),
    .wb_we_i    (WB_Reg_Write_i),
    .wb_idx_i   (WB_Write_Register_i),
    .wb_data_i  (WB_Write_Data_i),
    .data_o     (fwd1)
  );

  forward_mux #(.N(N)) u_fwd2 (
    .src_idx_i  (src2_idx),
    .src_data_i (src2_data),
    .wb_we_i    (WB_Reg_Write_i),
    .wb_idx_i   (WB_Write_Register_i),
    .wb_data_i  (WB_Write_Data_i),
    .data_o     (fwd2)
  );

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rr1_d   = rr1_q;
    rr2_d   = rr2_q;
    wr_d    = wr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    imm_d   = imm_q;
    bub_d   = bub_q;
    unique case (1'b1)
      sel_flush: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      sel_stall: begin
        op1_d = fwd1;
        op2_d = fwd2;
      end
      sel_bubble: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        bub_d   = sat_inc(bub_q);
      end
      sel_cap: begin
        valid_d = Valid_i;
        ctrl_d  = Valid_i ? ctrl_in : '0;
        rr1_d   = Read_Register_1_i;
        rr2_d   = Read_Register_2_i;
        wr_d    = Write_Register_i;
        op1_d   = fwd1;
        op2_d   = fwd2;
        imm_d   = Immediate_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rr1_q   <= '0;
      rr2_q   <= '0;
      wr_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      bub_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rr1_q   <= rr1_d;
      rr2_q   <= rr2_d;
      wr_q    <= wr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      bub_q   <= bub_d;
    end
  end

  assign Valid_o           = valid_q;
  assign Reg_Write_o       = ctrl_q.reg_write;
  assign Mem_Read_o        = ctrl_q.mem_read;
  assign Mem_Write_o       = ctrl_q.mem_write;
  assign Mem_To_Reg_o      = ctrl_q.mem_to_reg;
  assign ALU_Src_o         = ctrl_q.alu_src;
  assign ALU_Op_o          = ctrl_q.alu_op;
  assign Read_Register_1_o = rr1_q;
  assign Read_Register_2_o = rr2_q;
  assign Write_Register_o  = wr_q;
  assign Operand_1_o       = op1_q;
  assign Operand_2_o       = op2_q;
  assign Immediate_o       = imm_q;
  assign Hazard_Stall_o    = hazard;
  assign Bubble_Count_o    = bub_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bypass, load-use bubble,
// stall refresh, flush priority and asynchronous reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid_i, Stall_i, Flush_i;
  logic        Reg_Write_i, Mem_Read_i, Mem_Write_i;
  logic        Mem_To_Reg_i, ALU_Src_i;
  logic [3:0]  ALU_Op_i;
  logic [4:0]  Read_Register_1_i, Read_Register_2_i;
  logic [4:0]  Write_Register_i;
  logic [31:0] Read_Data_1_i, Read_Data_2_i, Immediate_i;
  logic        WB_Reg_Write_i;
  logic [4:0]  WB_Write_Register_i;
  logic [31:0] WB_Write_Data_i;
  logic        Valid_o, Reg_Write_o, Mem_Read_o, Mem_Write_o;
  logic        Mem_To_Reg_o, ALU_Src_o;
  logic [3:0]  ALU_Op_o;
  logic [4:0]  Read_Register_1_o, Read_Register_2_o;
  logic [4:0]  Write_Register_o;
  logic [31:0] Operand_1_o, Operand_2_o, Immediate_o;
  logic        Hazard_Stall_o;
  logic [15:0] Bubble_Count_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.N(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .Valid_i             (Valid_i),
    .Stall_i             (Stall_i),
    .Flush_i             (Flush_i),
    .Reg_Write_i         (Reg_Write_i),
    .Mem_Read_i          (Mem_Read_i),
    .Mem_Write_i         (Mem_Write_i),
    .Mem_To_Reg_i        (Mem_To_Reg_i),
    .ALU_Src_i           (ALU_Src_i),
    .ALU_Op_i            (ALU_Op_i),
    .Read_Register_1_i   (Read_Register_1_i),
    .Read_Register_2_i   (Read_Register_2_i),
    .Write_Register_i    (Write_Register_i),
    .Read_Data_1_i       (Read_Data_1_i),
    .Read_Data_2_i       (Read_Data_2_i),
    .Immediate_i         (Immediate_i),
    .WB_Reg_Write_i      (WB_Reg_Write_i),
    .WB_Write_Register_i (WB_Write_Register_i),
    .WB_Write_Data_i     (WB_Write_Data_i),
    .Valid_o             (Valid_o),
    .Reg_Write_o         (Reg_Write_o),
    .Mem_Read_o          (Mem_Read_o),
    .Mem_Write_o         (Mem_Write_o),
    .Mem_To_Reg_o        (Mem_To_Reg_o),
    .ALU_Src_o           (ALU_Src_o),
    .ALU_Op_o            (ALU_Op_o),
    .Read_Register_1_o   (Read_Register_1_o),
    .Read_Register_2_o   (Read_Register_2_o),
    .Write_Register_o    (Write_Register_o),
    .Operand_1_o         (Operand_1_o),
    .Operand_2_o         (Operand_2_o),
    .Immediate_o         (Immediate_o),
    .Hazard_Stall_o      (Hazard_Stall_o),
    .Bubble_Count_o      (Bubble_Count_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2,
                       input logic [4:0] wr, input logic mr);
    Valid_i           = 1'b1;
    Reg_Write_i       = 1'b1;
    Mem_Read_i        = mr;
    Mem_To_Reg_i      = mr;
    Read_Register_1_i = r1;
    Read_Data_1_i     = d1;
    Read_Register_2_i = r2;
    Read_Data_2_i     = d2;
    Write_Register_i  = wr;
  endtask

  initial begin
    reset = 1'b0;
    Valid_i = 0; Stall_i = 0; Flush_i = 0;
    Reg_Write_i = 0; Mem_Read_i = 0; Mem_Write_i = 0;
    Mem_To_Reg_i = 0; ALU_Src_i = 0; ALU_Op_i = '0;
    Read_Register_1_i = '0; Read_Register_2_i = '0;
    Write_Register_i = '0;
    Read_Data_1_i = '0; Read_Data_2_i = '0;
    Immediate_i = '0;
    WB_Reg_Write_i = 0; WB_Write_Register_i = '0;
    WB_Write_Data_i = '0;

    #2;
    chk("rst_valid", Valid_o, 0);
    chk("rst_bubbles", Bubble_Count_o, 0);
    chk("rst_op1", Operand_1_o, 0);
    #10 reset = 1'b1;

    // plain capture
    instr(5'd2, 32'd7, 5'd3, 32'd8, 5'd5, 1'b0);
    ALU_Op_i    = 4'h3;
    ALU_Src_i   = 1'b1;
    Immediate_i = 32'hFFFF_FFF0;
    step();
    chk("cap_op1", Operand_1_o, 7);
    chk("cap_op2", Operand_2_o, 8);
    chk("cap_valid", Valid_o, 1);
    chk("cap_wr", Write_Register_o, 5);
    chk("cap_aluop", ALU_Op_o, 4'h3);
    chk("cap_alusrc", ALU_Src_o, 1);
    chk("cap_imm", Immediate_o, 32'hFFFF_FFF0);

    // both operands bypass from write-back to reg 4
    ALU_Src_i = 1'b0;
    instr(5'd4, 32'd11, 5'd4, 32'd20, 5'd6, 1'b0);
    WB_Reg_Write_i = 1'b1;
    WB_Write_Register_i = 5'd4;
    WB_Write_Data_i = 32'd99;
    step();
    chk("byp_op2", Operand_2_o, 99);
    chk("byp_op1", Operand_1_o, 99);

    // write-back to reg 0 never bypasses
    instr(5'd0, 32'd0, 5'd0, 32'd13, 5'd6, 1'b0);
    WB_Write_Register_i = 5'd0;
    WB_Write_Data_i = 32'd55;
    step();
    chk("byp_r0_op2", Operand_2_o, 13);
    chk("byp_r0_op1", Operand_1_o, 0);
    WB_Reg_Write_i = 1'b0;

    // load-use: lw x25 followed by a reader of x25
    instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd25, 1'b1);
    step();
    chk("lw_memrd", Mem_Read_o, 1);
    instr(5'd25, 32'd40, 5'd6, 32'd41, 5'd7, 1'b0);
    #1;
    chk("lu_hazard", Hazard_Stall_o, 1);
    step();
    chk("lu_bub_valid", Valid_o, 0);
    chk("lu_bub_memrd", Mem_Read_o, 0);
    chk("lu_bub_regwr", Reg_Write_o, 0);
    chk("lu_bub_cnt", Bubble_Count_o, 1);
    chk("lu_hazard_clr", Hazard_Stall_o, 0);
    step();
    chk("lu_cap_valid", Valid_o, 1);
    chk("lu_cap_wr", Write_Register_o, 7);
    chk("lu_cap_op1", Operand_1_o, 40);

    // flush masks the hazard request and clears the stage
    instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd25, 1'b1);
    step();
    instr(5'd3, 32'd3, 5'd25, 32'd4, 5'd8, 1'b0);
    #1;
    chk("haz_pre_flush", Hazard_Stall_o, 1);
    Flush_i = 1'b1;
    #1;
    chk("haz_flush", Hazard_Stall_o, 0);
    step();
    Flush_i = 1'b0;
    chk("flush_valid", Valid_o, 0);
    chk("flush_memrd", Mem_Read_o, 0);
    chk("flush_cnt", Bubble_Count_o, 1);

    // stall hold with write-back refresh of held operand 1
    instr(5'd31, 32'd5, 5'd9, 32'd6, 5'd9, 1'b0);
    ALU_Op_i = 4'h5;
    step();
    chk("st_pre_op1", Operand_1_o, 5);
    Stall_i = 1'b1;
    instr(5'd3, 32'd100, 5'd4, 32'd101, 5'd12, 1'b0);
    ALU_Op_i = 4'h1;
    WB_Reg_Write_i = 1'b1;
    WB_Write_Register_i = 5'd31;
    WB_Write_Data_i = 32'd78;
    step();
    chk("st_op1", Operand_1_o, 78);
    chk("st_op2", Operand_2_o, 6);
    chk("st_rr1", Read_Register_1_o, 31);
    chk("st_wr", Write_Register_o, 9);
    chk("st_valid", Valid_o, 1);
    chk("st_aluop", ALU_Op_o, 4'h5);
    WB_Reg_Write_i = 1'b0;

    // flush beats stall
    Flush_i = 1'b1;
    step();
    chk("fs_valid", Valid_o, 0);
    chk("fs_regwr", Reg_Write_o, 0);
    Flush_i = 1'b0;
    Stall_i = 1'b0;

    // Valid_i low captures a zero-control bubble
    instr(5'd1, 32'd9, 5'd2, 32'd10, 5'd3, 1'b1);
    Valid_i = 1'b0;
    step();
    chk("inv_valid", Valid_o, 0);
    chk("inv_memrd", Mem_Read_o, 0);

    // asynchronous reset mid-stream, then resume
    instr(5'd1, 32'd21, 5'd2, 32'd22, 5'd3, 1'b0);
    step();
    chk("pre_rst_valid", Valid_o, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", Valid_o, 0);
    chk("arst_op1", Operand_1_o, 0);
    chk("arst_wr", Write_Register_o, 0);
    chk("arst_cnt", Bubble_Count_o, 0);
    chk("arst_regwr", Reg_Write_o, 0);
    #1 reset = 1'b1;
    step();
    chk("resume_valid", Valid_o, 1);
    chk("resume_op2", Operand_2_o, 22);
    chk("resume_cnt", Bubble_Count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
